// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 window generator built on two line buffers
module window_3x3_gen #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pix_in,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic [71:0] win_out,
   output logic        win_valid,
   input  logic        win_ready,
   output logic        frame_done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    lb0 [IMG_W];
   logic [7:0]    lb1 [IMG_W];
   logic [71:0]   sr;
   logic [71:0]   sr_nx;
   logic          acc;
   logic          prod;
   logic          col_last;
   logic          row_last;
   assign pix_ready = !rst && (!win_valid || win_ready);
   assign acc       = pix_valid && pix_ready;
   assign col_last  = col == CW'(IMG_W - 1);
   assign row_last  = row == RW'(IMG_H - 1);
   assign prod      = acc && (row >= RW'(2)) && (col >= CW'(2));
   // window shifted one column left with {LB0, LB1, pixel} as the new right column
   assign sr_nx = {pix_in, sr[71:56], lb1[col], sr[47:32], lb0[col], sr[23:8]};
   // raster position counters and end-of-frame pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= acc && col_last && row_last;
         if (acc) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) row <= row_last ? '0 : row + 1'b1;
         end
      end
   end
   // line buffers and column shift register; contents are never cleared
   always_ff @(posedge clk) begin
      if (acc) begin
         lb0[col] <= lb1[col];
         lb1[col] <= pix_in;
         sr       <= sr_nx;
      end
   end
   // single-entry output slot
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_out   <= '0;
      end else if (prod) begin
         win_valid <= 1'b1;
         win_out   <= sr_nx;
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks of the 3x3 window generator on 4x4 and 3x3 frames
module tb_window_3x3_gen;
   localparam logic [71:0] EXPW [4] = '{72'h0A0908060504020100, 72'h0B0A09070605030201,
                                        72'h0E0D0C0A0908060504, 72'h0F0E0D0B0A09070605};
   localparam logic [71:0] OFS  = 72'h101010101010101010;
   localparam logic [71:0] EXP3 = 72'h090807060504030201;
   logic        clk = 0;
   logic        rst = 1;
   logic [7:0]  pix_in4 = 0, pix_in3 = 0;
   logic        pix_valid4 = 0, pix_valid3 = 0;
   logic        pix_ready4, pix_ready3;
   logic [71:0] win_out4, win_out3;
   logic        win_valid4, win_valid3;
   logic        win_ready4 = 0, win_ready3 = 0;
   logic        frame_done4, frame_done3;
   logic [71:0] got[$];
   logic [71:0] got3[$];
   int          fd_cnt = 0, fd3_cnt = 0;
   int          checks = 0, errors = 0;

   window_3x3_gen #(.IMG_W(4), .IMG_H(4)) dut4 (
      .clk(clk), .rst(rst), .pix_in(pix_in4), .pix_valid(pix_valid4), .pix_ready(pix_ready4),
      .win_out(win_out4), .win_valid(win_valid4), .win_ready(win_ready4), .frame_done(frame_done4));
   window_3x3_gen #(.IMG_W(3), .IMG_H(3)) dut3 (
      .clk(clk), .rst(rst), .pix_in(pix_in3), .pix_valid(pix_valid3), .pix_ready(pix_ready3),
      .win_out(win_out3), .win_valid(win_valid3), .win_ready(win_ready3), .frame_done(frame_done3));

   always #5 clk = ~clk;

   // record every consumed window and every frame_done cycle
   always @(negedge clk) begin
      if (win_valid4 && win_ready4) got.push_back(win_out4);
      if (frame_done4) fd_cnt++;
      if (win_valid3 && win_ready3) got3.push_back(win_out3);
      if (frame_done3) fd3_cnt++;
   end

   task automatic cycle4(input logic v, input logic [7:0] d, input logic r, output logic a);
      pix_valid4 = v; pix_in4 = d; win_ready4 = r;
      @(negedge clk); a = v && pix_ready4;
      @(posedge clk); #1;
   endtask

   task automatic cycle3(input logic v, input logic [7:0] d, input logic r, output logic a);
      pix_valid3 = v; pix_in3 = d; win_ready3 = r;
      @(negedge clk); a = v && pix_ready3;
      @(posedge clk); #1;
   endtask

   task automatic feed4(input int first, input int last, input logic r, output int cyc);
      int i;
      logic a;
      i = first; cyc = 0;
      while (i <= last && cyc < 200) begin
         cycle4(1'b1, 8'(i), r, a);
         if (a) i++;
         cyc++;
      end
      pix_valid4 = 0;
      checks++;
      if (i <= last) begin errors++; $display("FAIL feed4: stalled at pixel %0d, required through %0d", i, last); end
   endtask

   task automatic idle4(input int n);
      logic a;
      for (int k = 0; k < n; k++) cycle4(1'b0, 8'h00, 1'b1, a);
   endtask

   task automatic do_reset;
      rst = 1; pix_valid4 = 0; win_ready4 = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_reset;
      pix_valid4 = 1; pix_in4 = 8'h55;
      @(posedge clk); #1;
      checks += 5;
      if (win_valid4 !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b, required 0", win_valid4); end
      if (win_out4 !== 72'h0) begin errors++; $display("FAIL reset_win_out: got %h, required 0", win_out4); end
      if (frame_done4 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, required 0", frame_done4); end
      if (pix_ready4 !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b, required 0", pix_ready4); end
      if (win_valid3 !== 1'b0) begin errors++; $display("FAIL reset_win_valid3: got %b, required 0", win_valid3); end
      @(posedge clk); #1;
      pix_valid4 = 0;
      rst = 0; #1;
      checks++;
      if (pix_ready4 !== 1'b1) begin errors++; $display("FAIL post_reset_pix_ready: got %b, required 1", pix_ready4); end
   endtask

   int nb, fb;

   task automatic test_first_window;
      int c;
      nb = got.size(); fb = fd_cnt;
      feed4(0, 9, 1'b1, c);
      checks++;
      if (win_valid4 !== 1'b0) begin errors++; $display("FAIL early_window: got win_valid %b, required 0", win_valid4); end
      feed4(10, 10, 1'b1, c);
      checks += 2;
      if (win_valid4 !== 1'b1) begin errors++; $display("FAIL first_valid: got %b, required 1", win_valid4); end
      if (win_out4 !== EXPW[0]) begin errors++; $display("FAIL first_window: got %h, required %h", win_out4, EXPW[0]); end
   endtask

   task automatic test_window_sequence;
      int c;
      logic a;
      feed4(11, 14, 1'b1, c);
      checks++;
      if (frame_done4 !== 1'b0) begin errors++; $display("FAIL early_frame_done: got %b, required 0", frame_done4); end
      feed4(15, 15, 1'b1, c);
      checks += 2;
      if (frame_done4 !== 1'b1) begin errors++; $display("FAIL frame_done_pulse: got %b, required 1", frame_done4); end
      if (win_out4 !== EXPW[3]) begin errors++; $display("FAIL last_window: got %h, required %h", win_out4, EXPW[3]); end
      cycle4(1'b0, 8'h00, 1'b1, a);
      checks++;
      if (frame_done4 !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b, required 0", frame_done4); end
      idle4(1);
      checks += 2;
      if (got.size() - nb !== 4) begin errors++; $display("FAIL seq_count: got %0d, required 4", got.size() - nb); end
      if (fd_cnt - fb !== 1) begin errors++; $display("FAIL seq_frame_done: got %0d, required 1", fd_cnt - fb); end
      for (int i = 0; i < 4 && nb + i < got.size(); i++) begin
         checks++;
         if (got[nb+i] !== EXPW[i]) begin errors++; $display("FAIL seq_window%0d: got %h, required %h", i, got[nb+i], EXPW[i]); end
      end
   endtask

   task automatic test_backpressure;
      int c;
      logic a;
      do_reset;
      nb = got.size();
      feed4(0, 10, 1'b1, c);
      for (int k = 0; k < 7; k++) begin
         cycle4(1'b1, 8'd11, 1'b0, a);
         checks += 3;
         if (a !== 1'b0) begin errors++; $display("FAIL bp_pix_ready: cycle %0d got accept %b, required 0", k, a); end
         if (win_valid4 !== 1'b1) begin errors++; $display("FAIL bp_valid: cycle %0d got %b, required 1", k, win_valid4); end
         if (win_out4 !== EXPW[0]) begin errors++; $display("FAIL bp_hold: cycle %0d got %h, required %h", k, win_out4, EXPW[0]); end
      end
      feed4(11, 15, 1'b1, c);
      idle4(2);
      checks++;
      if (got.size() - nb !== 4) begin errors++; $display("FAIL bp_count: got %0d, required 4", got.size() - nb); end
      for (int i = 0; i < 4 && nb + i < got.size(); i++) begin
         checks++;
         if (got[nb+i] !== EXPW[i]) begin errors++; $display("FAIL bp_window%0d: got %h, required %h", i, got[nb+i], EXPW[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int c;
      logic [71:0] e;
      do_reset;
      nb = got.size(); fb = fd_cnt;
      feed4(0, 31, 1'b1, c);
      idle4(2);
      checks += 3;
      if (c !== 32) begin errors++; $display("FAIL b2b_cycles: got %0d, required 32", c); end
      if (got.size() - nb !== 8) begin errors++; $display("FAIL b2b_count: got %0d, required 8", got.size() - nb); end
      if (fd_cnt - fb !== 2) begin errors++; $display("FAIL b2b_frame_done: got %0d, required 2", fd_cnt - fb); end
      for (int i = 0; i < 8 && nb + i < got.size(); i++) begin
         e = (i < 4) ? EXPW[i] : EXPW[i-4] + OFS;
         checks++;
         if (got[nb+i] !== e) begin errors++; $display("FAIL b2b_window%0d: got %h, required %h", i, got[nb+i], e); end
      end
   endtask

   task automatic test_reset_mid_frame;
      int c;
      do_reset;
      feed4(0, 9, 1'b1, c);
      feed4(10, 10, 1'b0, c);
      nb = got.size();
      checks++;
      if (win_valid4 !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b, required 1", win_valid4); end
      rst = 1; win_ready4 = 0;
      @(negedge clk);
      checks++;
      if (pix_ready4 !== 1'b0) begin errors++; $display("FAIL mid_pix_ready: got %b, required 0", pix_ready4); end
      @(posedge clk); #1;
      rst = 0;
      checks += 3;
      if (win_valid4 !== 1'b0) begin errors++; $display("FAIL mid_win_valid: got %b, required 0", win_valid4); end
      if (win_out4 !== 72'h0) begin errors++; $display("FAIL mid_win_out: got %h, required 0", win_out4); end
      if (got.size() !== nb) begin errors++; $display("FAIL mid_dropped: got %0d consumed, required 0", got.size() - nb); end
      fb = fd_cnt;
      feed4(0, 15, 1'b1, c);
      idle4(2);
      checks += 2;
      if (got.size() - nb !== 4) begin errors++; $display("FAIL mid_count: got %0d, required 4", got.size() - nb); end
      if (fd_cnt - fb !== 1) begin errors++; $display("FAIL mid_frame_done: got %0d, required 1", fd_cnt - fb); end
      for (int i = 0; i < 4 && nb + i < got.size(); i++) begin
         checks++;
         if (got[nb+i] !== EXPW[i]) begin errors++; $display("FAIL mid_window%0d: got %h, required %h", i, got[nb+i], EXPW[i]); end
      end
   endtask

   task automatic test_min_size;
      int i, c, n3, f3;
      logic a;
      n3 = got3.size(); f3 = fd3_cnt;
      i = 1; c = 0;
      while (i <= 9 && c < 100) begin
         cycle3(1'b1, 8'(i), 1'(c % 2), a);
         if (a) i++;
         c++;
      end
      pix_valid3 = 0;
      checks += 3;
      if (i <= 9) begin errors++; $display("FAIL min_feed: stalled at pixel %0d, required through 9", i); end
      if (win_valid3 !== 1'b1) begin errors++; $display("FAIL min_valid: got %b, required 1", win_valid3); end
      if (win_out3 !== EXP3) begin errors++; $display("FAIL min_window: got %h, required %h", win_out3, EXP3); end
      for (int k = 0; k < 6; k++) begin
         if (got3.size() == n3) begin
            checks += 2;
            if (win_valid3 !== 1'b1) begin errors++; $display("FAIL min_hold_valid: cycle %0d got %b, required 1", k, win_valid3); end
            if (win_out3 !== EXP3) begin errors++; $display("FAIL min_hold: cycle %0d got %h, required %h", k, win_out3, EXP3); end
         end
         cycle3(1'b0, 8'h00, 1'(c % 2), a);
         c++;
      end
      checks += 3;
      if (got3.size() - n3 !== 1) begin errors++; $display("FAIL min_count: got %0d, required 1", got3.size() - n3); end
      if (win_valid3 !== 1'b0) begin errors++; $display("FAIL min_drained: got %b, required 0", win_valid3); end
      if (fd3_cnt - f3 !== 1) begin errors++; $display("FAIL min_frame_done: got %0d, required 1", fd3_cnt - f3); end
      if (got3.size() > n3) begin
         checks++;
         if (got3[n3] !== EXP3) begin errors++; $display("FAIL min_consumed: got %h, required %h", got3[n3], EXP3); end
      end
   endtask

   initial begin
      test_reset;
      test_first_window;
      test_window_sequence;
      test_backpressure;
      test_back_to_back;
      test_reset_mid_frame;
      test_min_size;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
